// File: rtl/mem_arbiter.sv
// Two-port (CPU / IO) arbiter in front of a single-port synchronous RAM.
// Ties go to the port not served last; loads return data two cycles after the grant.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        io_req,
    input  logic        io_we,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    output logic        io_gnt,
    output logic        io_rvalid,
    output logic [15:0] io_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    localparam logic PORT_IO = 1'b1;

    state_t      state_reg;
    state_t      state_next;
    logic        owner_reg;
    logic        last_owner_reg;
    logic        mem_we_reg;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic        winner;
    logic        start;

    // Port 0 is the CPU, port 1 is IO.
    logic [1:0]  req;
    logic [1:0]  we_in;
    logic [15:0] addr_in  [2];
    logic [15:0] wdata_in [2];
    logic [1:0]  gnt;
    logic [1:0]  rvalid_reg;
    logic [15:0] rdata_reg [2];

    assign req         = {io_req, cpu_req};
    assign we_in       = {io_we, cpu_we};
    assign addr_in[0]  = cpu_addr;
    assign addr_in[1]  = io_addr;
    assign wdata_in[0] = cpu_wdata;
    assign wdata_in[1] = io_wdata;

    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_owner_reg;
        end
    end

    assign start = (state_reg == IDLE) && (|req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? ACCESS : IDLE;
            ACCESS:  state_next = mem_we_reg ? IDLE : RDWAIT;
            RDWAIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt  = 2'b00;
        busy = (state_reg != IDLE);
        if (state_reg == ACCESS) begin
            gnt[owner_reg] = 1'b1;
        end
    end

    // Request fields are only looked at when leaving IDLE; otherwise the RAM-side
    // registers keep their last values and the write strobe falls after one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg      <= 1'b0;
            last_owner_reg <= PORT_IO;
            mem_we_reg     <= 1'b0;
            addr_reg       <= 16'h0000;
            wdata_reg      <= 16'h0000;
        end else if (start) begin
            owner_reg      <= winner;
            last_owner_reg <= winner;
            mem_we_reg     <= we_in[winner];
            addr_reg       <= addr_in[winner];
            wdata_reg      <= wdata_in[winner];
        end else begin
            mem_we_reg     <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= 16'h0000;
                end else begin
                    rvalid_reg[gi] <= (state_reg == RDWAIT) && (owner_reg == 1'(gi));
                    if ((state_reg == RDWAIT) && (owner_reg == 1'(gi))) begin
                        rdata_reg[gi] <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign mem_we     = mem_we_reg;
    assign cpu_gnt    = gnt[0];
    assign io_gnt     = gnt[1];
    assign cpu_rvalid = rvalid_reg[0];
    assign io_rvalid  = rvalid_reg[1];
    assign cpu_rdata  = rdata_reg[0];
    assign io_rdata   = rdata_reg[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model (memory array, last-served port, per-port expected rdata).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
    logic [15:0] cpu_rdata, io_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] ram       [256];
    logic [15:0] model_mem [256];
    logic [15:0] exp_rdata [2];
    int          model_last;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port synchronous RAM, read-before-write, cleared by reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
            mem_rdata <= 16'h0000;
        end else begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        model_last   = 1;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    endtask

    // Entered #1 after an edge with the DUT idle and at least one req high.
    task automatic serve(input bit keep);
        int          w;
        logic        we;
        logic [15:0] a, d;
        if (cpu_req && io_req) w = (model_last == 1) ? 0 : 1;
        else                   w = cpu_req ? 0 : 1;
        we = (w == 0) ? cpu_we    : io_we;
        a  = (w == 0) ? cpu_addr  : io_addr;
        d  = (w == 0) ? cpu_wdata : io_wdata;
        @(posedge clk); #1;
        chk1("cpu_gnt", cpu_gnt, w == 0);
        chk1("io_gnt", io_gnt, w == 1);
        chk1("busy_access", busy, 1'b1);
        chk1("rvalid_access", cpu_rvalid | io_rvalid, 1'b0);
        chk1("mem_we_access", mem_we, we);
        chk16("mem_addr", mem_addr, a);
        if (we) chk16("mem_wdata", mem_wdata, d);
        model_last = w;
        if (!keep) begin
            if (w == 0) cpu_req = 1'b0;
            else        io_req  = 1'b0;
        end
        if (we) begin
            model_mem[a[7:0]] = d;
            @(posedge clk); #1;
            chk1("busy_after_wr", busy, 1'b0);
            chk1("mem_we_after_wr", mem_we, 1'b0);
            chk1("gnt_after_wr", cpu_gnt | io_gnt, 1'b0);
            chk16("mem_addr_hold", mem_addr, a);
        end else begin
            @(posedge clk); #1;
            chk1("busy_rdwait", busy, 1'b1);
            chk1("mem_we_rdwait", mem_we, 1'b0);
            chk1("gnt_rdwait", cpu_gnt | io_gnt, 1'b0);
            chk1("rvalid_rdwait", cpu_rvalid | io_rvalid, 1'b0);
            @(posedge clk); #1;
            exp_rdata[w] = model_mem[a[7:0]];
            chk1("cpu_rvalid", cpu_rvalid, w == 0);
            chk1("io_rvalid", io_rvalid, w == 1);
            chk1("busy_rvalid", busy, 1'b0);
        end
        chk16("cpu_rdata", cpu_rdata, exp_rdata[0]);
        chk16("io_rdata", io_rdata, exp_rdata[1]);
        $display("txn port=%s we=%0d addr=%h wdata=%h", (w == 0) ? "cpu" : "io", we, a, d);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        io_req  = 1'b0; io_we  = 1'b0; io_addr  = 16'h0; io_wdata  = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_gnt", cpu_gnt | io_gnt, 1'b0);
        chk1("rst_rvalid", cpu_rvalid | io_rvalid, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        chk16("rst_mem_wdata", mem_wdata, 16'h0000);
        chk16("rst_cpu_rdata", cpu_rdata, 16'h0000);
        chk16("rst_io_rdata", io_rdata, 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;
        chk1("idle_gnt", cpu_gnt | io_gnt, 1'b0);
        chk1("idle_busy", busy, 1'b0);

        // CPU store then IO load of the same word
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        serve(1'b0);
        io_req = 1'b1; io_we = 1'b0; io_addr = 16'h0010;
        serve(1'b0);
        chk16("io_rdata_beef", io_rdata, 16'hBEEF);

        // Both ports requesting continuously: strict alternation
        cpu_we = 1'b0; cpu_addr = 16'h0010; io_we = 1'b1; io_addr = 16'h0003; io_wdata = 16'h1234;
        cpu_req = 1'b1; io_req = 1'b1;
        repeat (4) serve(1'b1);
        cpu_req = 1'b0; io_req = 1'b0;
        @(posedge clk); #1;

        // Back-to-back CPU loads: second arbitration in the rvalid cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
        serve(1'b1);
        serve(1'b0);

        // Reset in RDWAIT of an IO load with a CPU request pending
        io_req = 1'b1; io_we = 1'b0; io_addr = 16'h0010;
        @(posedge clk); #1;
        chk1("abort_io_gnt", io_gnt, 1'b1);
        io_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(posedge clk); #1;
        chk1("abort_busy_rdwait", busy, 1'b1);
        chk1("abort_cpu_ignored", cpu_gnt, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk1("abort_io_rvalid", io_rvalid, 1'b0);
        chk16("abort_io_rdata", io_rdata, 16'h0000);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_gnt", cpu_gnt | io_gnt, 1'b0);
        chk1("abort_mem_we", mem_we, 1'b0);
        reset = 1'b0;
        model_reset();
        serve(1'b0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            if (!cpu_req && ($urandom_range(0, 1) == 1)) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            if (!io_req && ($urandom_range(0, 1) == 1)) begin
                io_req   = 1'b1;
                io_we    = 1'($urandom_range(0, 1));
                io_addr  = 16'($urandom_range(0, 15));
                io_wdata = 16'($urandom);
            end
            if (cpu_req || io_req) begin
                serve(1'b0);
            end else begin
                @(posedge clk); #1;
                chk1("rand_idle_gnt", cpu_gnt | io_gnt, 1'b0);
                chk1("rand_idle_busy", busy, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
